// File: rtl/cell_writer_pkg.sv
// Shared definitions for the cell writer: op and status codes, FSM states,
// and the bit positions of the protect, blank and digit fields in a row word.
package cell_writer_pkg;

   typedef enum logic [1:0] {
      OP_SET       = 2'd0,
      OP_CLEAR     = 2'd1,
      OP_CLEAR_ALL = 2'd2,
      OP_RSVD      = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_PROTECTED = 2'd1,
      ST_BAD       = 2'd2,
      ST_LOCKED    = 2'd3
   } status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MOD,
      S_WR,
      S_RSP
   } state_t;

   localparam int WORD_W    = 24;
   localparam int DIGIT_W   = 4;
   localparam int NUM_COLS  = 4;
   localparam int DIGIT_LSB = 0;
   localparam int BLANK_LSB = 16;
   localparam int PROT_LSB  = 20;

endpackage

// File: rtl/cell_writer_merge.sv
// Combinational row-word editor: applies SET, CLEAR or CLEAR_ALL to a row
// word and flags protected targets and malformed requests.
module cell_merge
   import cell_writer_pkg::*;
#(
   parameter int DIGIT_MAX = 4
) (
   input  logic [WORD_W-1:0]  word,
   input  logic [1:0]         col,
   input  op_t                op,
   input  logic [DIGIT_W-1:0] digit,
   output logic [WORD_W-1:0]  new_word,
   output logic               prot,
   output logic               bad
);

   always_comb begin
      new_word = word;
      bad      = (op == OP_RSVD) ||
                 ((op == OP_SET) && ((digit == '0) || (32'(digit) > DIGIT_MAX)));
      prot     = ((op == OP_SET) || (op == OP_CLEAR)) && word[PROT_LSB + int'(col)];
      // Protected cells are never touched, whether targeted alone or by CLEAR_ALL.
      for (int c = 0; c < NUM_COLS; c++) begin
         if (((op == OP_CLEAR_ALL) || (c[1:0] == col)) && !word[PROT_LSB + c]) begin
            if (op == OP_SET) begin
               new_word[DIGIT_LSB + DIGIT_W*c +: DIGIT_W] = digit;
               new_word[BLANK_LSB + c]                    = 1'b0;
            end else if ((op == OP_CLEAR) || (op == OP_CLEAR_ALL)) begin
               new_word[DIGIT_LSB + DIGIT_W*c +: DIGIT_W] = '0;
               new_word[BLANK_LSB + c]                    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/cell_writer.sv
// Read-modify-write editor for a 4x4 board held one row per RAM word.
// Optional CELL_WRITER_WIN_LOCK_EN rejects all edits once the game is won.
module cell_writer
   import cell_writer_pkg::*;
#(
   parameter int DIGIT_MAX = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [1:0]         req_row,
   input  logic [1:0]         req_col,
   input  logic [3:0]         req_digit,
   input  logic               game_complete,
   output logic               resp_valid,
   output logic [1:0]         resp_status,
   output logic [1:0]         RamAddr,
   input  logic [WORD_W-1:0]  RamRdDat,
   output logic [WORD_W-1:0]  RamWrDat,
   output logic               RamWE
);

   state_t              state, state_next;
   op_t                 op_q;
   logic [1:0]          row_q, col_q, row_cnt, addr;
   logic [DIGIT_W-1:0]  digit_q;
   logic [WORD_W-1:0]   rd_word, wr_q, merged;
   status_t             status_q, status_now;
   logic                prot, bad, locked;

`ifdef CELL_WRITER_WIN_LOCK_EN
   assign locked = game_complete;
`else
   logic unused_game;
   assign locked      = 1'b0;
   assign unused_game = game_complete;
`endif

   cell_merge #(.DIGIT_MAX(DIGIT_MAX)) u_merge (
      .word     (rd_word),
      .col      (col_q),
      .op       (op_q),
      .digit    (digit_q),
      .new_word (merged),
      .prot     (prot),
      .bad      (bad)
   );

   assign addr = (op_q == OP_CLEAR_ALL) ? row_cnt : row_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         op_q     <= OP_SET;
         row_q    <= '0;
         col_q    <= '0;
         digit_q  <= '0;
         rd_word  <= '0;
         wr_q     <= '0;
         status_q <= ST_OK;
         row_cnt  <= '0;
      end else begin
         state <= state_next;
         case (state)
            S_IDLE: if (req_valid) begin
               op_q    <= op_t'(req_op);
               row_q   <= req_row;
               col_q   <= req_col;
               digit_q <= req_digit;
            end
            S_RD:  rd_word <= RamRdDat;
            S_MOD: begin
               wr_q     <= merged;
               status_q <= status_now;
            end
            S_WR:  if ((op_q == OP_CLEAR_ALL) && (row_cnt != 2'd3)) row_cnt <= row_cnt + 2'd1;
            S_RSP: row_cnt <= '0;
            default: ;
         endcase
      end
   end

   // Reset masks every output in the same cycle so an in-flight write or
   // response is dropped rather than completed.
   always_comb begin
      state_next  = state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_status = ST_OK;
      RamAddr     = '0;
      RamWrDat    = '0;
      RamWE       = 1'b0;
      status_now  = locked ? ST_LOCKED : bad ? ST_BAD : prot ? ST_PROTECTED : ST_OK;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = S_RD;
         end
         S_RD: begin
            RamAddr    = addr;
            state_next = S_MOD;
         end
         S_MOD: begin
            RamAddr    = addr;
            state_next = (status_now == ST_OK) ? S_WR : S_RSP;
         end
         S_WR: begin
            RamAddr    = addr;
            RamWE      = 1'b1;
            RamWrDat   = wr_q;
            state_next = ((op_q == OP_CLEAR_ALL) && (row_cnt != 2'd3)) ? S_RD : S_RSP;
         end
         S_RSP: begin
            resp_valid  = 1'b1;
            resp_status = status_q;
            state_next  = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (RST) begin
         req_ready   = 1'b0;
         resp_valid  = 1'b0;
         resp_status = ST_OK;
         RamAddr     = '0;
         RamWrDat    = '0;
         RamWE       = 1'b0;
      end
   end

endmodule
